// File: rtl/geogenius_pkg.sv
// Shared constants, state encoding and helpers for the geogenius game input path.
package geogenius_pkg;

  localparam int unsigned N_BOTOES         = 8;
  localparam int unsigned DEBOUNCE_DEFAULT = 50000;

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    FILTRA = 2'd1,
    ACEITA = 2'd2,
    SOLTA  = 2'd3
  } estado_t;

  // True when exactly one bit of the play vector is set.
  function automatic logic eh_one_hot(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
  endfunction

endpackage

// File: rtl/condicionador_botoes_sincronizador.sv
// N-bit two-flop synchroniser for asynchronous button levels.
module sincronizador
  import geogenius_pkg::*;
#(
  parameter int unsigned W = N_BOTOES
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Button conditioner: sync, debounce, press-then-release, chord rejection -> one-hot play + strobe.
// Optional chord reporting on o_multi_press when MULTI_PRESS_DETECT_EN is defined.
module condicionador_botoes
  import geogenius_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_DEFAULT
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_habilita,
  input  logic [N_BOTOES-1:0] i_botoes,
  output logic [N_BOTOES-1:0] o_jogada,
  output logic                o_fez_jogada,
  output logic                o_multi_press,
  output logic [1:0]          o_db_estado
);

  localparam int unsigned          CNT_W   = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] w_s;
  estado_t             r_estado;
  logic [CNT_W-1:0]    r_cnt;
  logic [N_BOTOES-1:0] r_cand;
  logic [N_BOTOES-1:0] r_jogada;
  logic                r_fez_jogada;
`ifdef MULTI_PRESS_DETECT_EN
  logic                r_multi_press;
`endif

  sincronizador #(.W(N_BOTOES)) u_sinc (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_botoes),
    .o_q     (w_s)
  );

  // Debounce FSM; the counter only leaves a state at terminal count, so it never wraps.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_estado     <= SOLTA;
      r_cnt        <= '0;
      r_cand       <= '0;
      r_jogada     <= '0;
      r_fez_jogada <= 1'b0;
`ifdef MULTI_PRESS_DETECT_EN
      r_multi_press <= 1'b0;
`endif
    end else begin
      r_fez_jogada <= 1'b0;
`ifdef MULTI_PRESS_DETECT_EN
      r_multi_press <= 1'b0;
`endif
      case (r_estado)
        ESPERA: begin
          r_cnt <= '0;
          if (i_habilita && (w_s != '0)) begin
            r_cand   <= w_s;
            r_estado <= FILTRA;
          end
        end
        FILTRA: begin
          if (!i_habilita) begin
            r_cnt    <= '0;
            r_estado <= SOLTA;
          end else if (w_s == '0) begin
            r_cnt    <= '0;
            r_estado <= ESPERA;
          end else if (w_s != r_cand) begin
            r_cand <= w_s;
            r_cnt  <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_cnt    <= '0;
            r_estado <= ACEITA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ACEITA: begin
          if (eh_one_hot(r_cand)) begin
            r_jogada     <= r_cand;
            r_fez_jogada <= 1'b1;
          end
`ifdef MULTI_PRESS_DETECT_EN
          else begin
            r_multi_press <= 1'b1;
          end
`endif
          r_cnt    <= '0;
          r_estado <= SOLTA;
        end
        SOLTA: begin
          // Any activity restarts the release window; the play is re-armed only after a clean release.
          if (w_s != '0) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_cnt    <= '0;
            r_estado <= ESPERA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt    <= '0;
          r_estado <= SOLTA;
        end
      endcase
    end
  end

  assign o_jogada     = r_jogada;
  assign o_fez_jogada = r_fez_jogada;
  assign o_db_estado  = 2'(r_estado);
`ifdef MULTI_PRESS_DETECT_EN
  assign o_multi_press = r_multi_press;
`else
  assign o_multi_press = 1'b0;
`endif

endmodule
